// File: rtl/seq_mul_32_if.sv
// Start/done handshake and operand/result bus for the iterative multiplier.
interface seq_mul_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  // Requester side: issues operands, watches status and result.
  modport master (
    output start, is_signed, a, b,
    input  busy, done, product_hi, product_lo
  );

  // Multiplier side.
  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/seq_mul_32.sv
// Iterative shift-add multiplier: one partial-product accumulation per clock,
// signed operands handled as magnitudes with a final conditional negation.
module seq_mul_32 #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mul_32_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state;
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] fixed;

  // Operand magnitudes, one adder step, and the sign-corrected result.
  // The most-negative operand negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  always_comb begin
    a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    sum   = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    fixed = neg ? (~{acc, mplier} + (2*WIDTH)'(1)) : {acc, mplier};
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // {carry, acc, mplier} shifted right by one after the add.
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          prod_hi_q <= fixed[2*WIDTH-1:WIDTH];
          prod_lo_q <= fixed[WIDTH-1:0];
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;

endmodule

// File: tb/tb_seq_mul_32.sv
// Directed bench for seq_mul_32: vector table plus handshake/reset corner cases.
module tb_seq_mul_32;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // edges from start edge until done is visible
  localparam int TMO = 200;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_mul_32_if #(.WIDTH(W)) bus ();

  seq_mul_32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation starting just after a posedge; returns product,
  // edges until done, busy-high sample count and done pulse width.
  task automatic run_op(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] p, output int lat, output int bcnt,
                        output int dwidth);
    lat = -1; bcnt = 0; dwidth = 0;
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy) bcnt++;
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    p = {bus.product_hi, bus.product_lo};
    while (bus.done && dwidth < 5) begin
      dwidth++;
      @(posedge clk); #1;
    end
  endtask

  logic [2*W-1:0] p;
  int lat, bcnt, dw, dcount;

  initial begin
    n_checks = 0; n_fail = 0;
    vecs[0]  = '{1'b0, 32'h00000007, 32'h00000006, 64'h00000000_0000002A};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[4]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[5]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB, 32'h00000000, 64'h00000000_00000000};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[8]  = '{1'b1, 32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6};
    vecs[9]  = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[10] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", {bus.product_hi, bus.product_lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, p, lat, bcnt, dw);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(LAT));
      check($sformatf("vec%0d_done_width", i), 64'(dw), 64'd1);
      // Product holds through IDLE.
      @(posedge clk); #1;
      check($sformatf("vec%0d_hold", i), {bus.product_hi, bus.product_lo}, vecs[i].exp);
    end

    // Start pulsed mid-RUN with new operands is ignored.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcount = 0; lat = -1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.done) begin
        dcount++;
        if (lat < 0) p = {bus.product_hi, bus.product_lo};
        lat = i;
      end
      if (!bus.done && !bus.busy && lat >= 0 && i > lat + 3) break;
      @(posedge clk); #1;
    end
    check("busy_protect_seen", 64'(lat >= 0), 64'd1);
    check("busy_protect_product", p, 64'h51);
    check("busy_protect_done_pulses", 64'(dcount), 64'd1);

    // Start held through DONE is taken only in the following IDLE cycle.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    check("held_first_latency", 64'(lat), 64'(LAT));
    @(posedge clk); #1;   // DONE -> IDLE, start ignored while in DONE
    check("held_idle_busy", 64'(bus.busy), 64'd0);
    check("held_idle_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;   // accepted in IDLE
    check("held_second_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    check("held_second_latency", 64'(lat), 64'(LAT));
    check("held_second_product", {bus.product_hi, bus.product_lo}, 64'd15);
    @(posedge clk); #1;

    // Asynchronous reset at RUN iteration 10 aborts with no done pulse.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd100; bus.b = 32'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_product", {bus.product_hi, bus.product_lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcount++;
    end
    check("midreset_no_activity", 64'(dcount), 64'd0);
    run_op(1'b0, 32'd12, 32'd12, p, lat, bcnt, dw);
    check("post_reset_product", p, 64'h90);
    check("post_reset_latency", 64'(lat), 64'(LAT));
    check("post_reset_done_width", 64'(dw), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
